hs_fifo_producer: RTL

//  Producer side of the req/ack channel (clk3 domain). Buffers words from a local

---
 rtl/hs_channel_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/hs_fifo_producer.sv | 95 +++++++++
 3 files changed

// File: rtl/hs_channel_pkg.sv
// ============================================================================
//  Module      : hs_channel_pkg
//  Description : Shared types and helpers for the req/ack channel producer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hs_channel_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    // One extra MSB beyond the address bits distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import hs_channel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == PTR_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Guard here so a full/empty violation from the caller can never corrupt pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hs_fifo_producer.sv
// ============================================================================
//  Module      : hs_fifo_producer
//  Description : FIFO-backed producer answering a 4-phase req/ack channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_fifo_producer
    import hs_channel_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk3,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   ch_req,
    output logic                   ch_ack,
    output logic [DATA_W-1:0]      ch_data,
    output logic [$clog2(DEPTH):0] level
);

    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                   req_s;
    hs_state_e              state_q, state_d;
    logic [DATA_W-1:0]      ch_data_q, ch_data_d;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_rd_data;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk3),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (fifo_rd_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign req_s    = req_sync_q[SYNC_STAGES-1];
    assign ch_ack   = (state_q == HS_ACK);
    assign ch_data  = ch_data_q;

    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], ch_req};
    end

    // One pop per request phase: the pop is tied to the IDLE->ACK transition only.
    always_comb begin
        state_d   = state_q;
        ch_data_d = ch_data_q;
        fifo_pop  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (req_s && !fifo_empty) begin
                    ch_data_d = fifo_rd_data;
                    fifo_pop  = 1'b1;
                    state_d   = HS_ACK;
                end
            end
            HS_ACK: begin
                if (!req_s) begin
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk3) begin
        if (rst) begin
            req_sync_q <= '0;
            state_q    <= HS_IDLE;
            ch_data_q  <= '0;
        end else begin
            req_sync_q <= req_sync_d;
            state_q    <= state_d;
            ch_data_q  <= ch_data_d;
        end
    end

endmodule

`default_nettype wire
